stage_responder: RTL and testbench

Plant-side responder for the four-stage sequencer controller. Consumes the controller's one-hot stage enables `en1`..`en4`, runs a timed action for the active stage, and returns the stage-complete inputs `sw1`..`sw3` that the controller uses in manual mode to advance. Stage 4 runs to completion on its own and signals the end of the sequence. The block sits between the sequencer and the actuator/timer logic, on the same clock as the sequencer.

---
 rtl/stage_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_stage_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_responder.sv
// stage_responder
// Plant-side responder for the four-stage sequencer. It watches the one-hot
// stage enables, times the active stage, and reports completion back to
// the controller.
//
// Parameters:
//   T1..T4  stage durations in clock cycles (1 .. 2^CW-1)
//   CW      duration counter width
//   WDT     done-hold watchdog limit in cycles (only with STAGE_WDT_EN)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   en1..en4   stage enables from the controller (one-hot or all low)
//   sw1..sw3   stage-k complete level, returned to the controller
//   seq_done   one-cycle pulse when stage 4 completes
//   busy       high while a stage timer is running
//   stage      0 = idle, 1..4 = active stage
//   fault      illegal enable pattern or watchdog trip
//   dbg_state  current FSM state (IDLE=0, RUN=1, DONE=2, FAULT=3)
//
// Build option: define STAGE_WDT_EN to add the done-hold watchdog. Without
// it, DONE holds for as long as the stage enable stays high.
//
// Enable handshake: en_k is a level, sampled at every rising edge. sw_k is
// a level that stays high for as long as en_k stays high after the stage
// completes, and it falls at the first edge where en_k is sampled low.
module stage_responder #(
  parameter int T1  = 8,
  parameter int T2  = 8,
  parameter int T3  = 12,
  parameter int T4  = 4,
  parameter int CW  = 8,
  parameter int WDT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en1,
  input  logic       en2,
  input  logic       en3,
  input  logic       en4,
  output logic       sw1,
  output logic       sw2,
  output logic       sw3,
  output logic       seq_done,
  output logic       busy,
  output logic [2:0] stage,
  output logic       fault,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam longint TMAX = (longint'(1) << CW) - 1;

  generate
    if (T1 < 1 || T1 > TMAX) begin : g_bad_t1
      $error("stage_responder: T1 out of range");
    end
    if (T2 < 1 || T2 > TMAX) begin : g_bad_t2
      $error("stage_responder: T2 out of range");
    end
    if (T3 < 1 || T3 > TMAX) begin : g_bad_t3
      $error("stage_responder: T3 out of range");
    end
    if (T4 < 1 || T4 > TMAX) begin : g_bad_t4
      $error("stage_responder: T4 out of range");
    end
  endgenerate

  localparam logic [CW-1:0] LD1 = CW'(T1 - 1);
  localparam logic [CW-1:0] LD2 = CW'(T2 - 1);
  localparam logic [CW-1:0] LD3 = CW'(T3 - 1);
  localparam logic [CW-1:0] LD4 = CW'(T4 - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    sw_q;
  logic [3:0]    en;
  logic          valid;
  logic          multi;
  logic [1:0]    sidx;
  logic          own_only;
  logic [2:0]    start_stage;
  logic [CW-1:0] start_load;

  assign en        = {en4, en3, en2, en1};
  assign valid     = $onehot(en);
  assign multi     = !$onehot0(en);
  // stage 1..4 maps to enable bit 0..3; stage 0 wraps to 3 but is never
  // looked at outside RUN/DONE.
  assign sidx      = stage[1:0] - 2'd1;
  assign own_only  = (en == (4'b0001 << sidx));
  assign sw1       = sw_q[0];
  assign sw2       = sw_q[1];
  assign sw3       = sw_q[2];
  assign dbg_state = state;

  // Stage number and counter preload for a fresh entry from the enables.
  always_comb begin
    start_stage = 3'd0;
    start_load  = '0;
    unique case (en)
      4'b0001: begin start_stage = 3'd1; start_load = LD1; end
      4'b0010: begin start_stage = 3'd2; start_load = LD2; end
      4'b0100: begin start_stage = 3'd3; start_load = LD3; end
      4'b1000: begin start_stage = 3'd4; start_load = LD4; end
      default: ;
    endcase
  end

`ifdef STAGE_WDT_EN
  localparam int HW = (WDT < 2) ? 1 : $clog2(WDT);
  logic [HW-1:0] hold;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sw_q     <= '0;
      seq_done <= 1'b0;
      busy     <= 1'b0;
      stage    <= 3'd0;
      fault    <= 1'b0;
`ifdef STAGE_WDT_EN
      hold     <= '0;
`endif
    end else begin
      seq_done <= 1'b0;
`ifdef STAGE_WDT_EN
      hold     <= '0;
`endif
      if (multi) begin
        // Multi-hot enables win over everything, including stage 4.
        state <= S_FAULT;
        fault <= 1'b1;
        sw_q  <= '0;
        busy  <= 1'b0;
        stage <= 3'd0;
        cnt   <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (valid) begin
              state <= S_RUN;
              stage <= start_stage;
              cnt   <= start_load;
              busy  <= 1'b1;
            end
          end
          S_RUN: begin
            if (stage == 3'd4) begin
              // Stage 4 ignores enable changes until it times out.
              if (cnt == '0) begin
                state    <= S_IDLE;
                seq_done <= 1'b1;
                busy     <= 1'b0;
                stage    <= 3'd0;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end else if (own_only) begin
              if (cnt == '0) begin
                state <= S_DONE;
                sw_q  <= en[2:0];
                busy  <= 1'b0;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end else if (valid) begin
              stage <= start_stage;
              cnt   <= start_load;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              stage <= 3'd0;
              cnt   <= '0;
            end
          end
          S_DONE: begin
            if (own_only) begin
`ifdef STAGE_WDT_EN
              if (hold == HW'(WDT - 1)) begin
                state <= S_FAULT;
                fault <= 1'b1;
                sw_q  <= '0;
                stage <= 3'd0;
              end else begin
                hold <= hold + 1'b1;
              end
`endif
            end else if (valid) begin
              // Normal controller advance: en_k drops and en_j rises together.
              sw_q  <= '0;
              state <= S_RUN;
              stage <= start_stage;
              cnt   <= start_load;
              busy  <= 1'b1;
            end else begin
              sw_q  <= '0;
              state <= S_IDLE;
              stage <= 3'd0;
            end
          end
          default: begin
            if (en == 4'b0000) begin
              state <= S_IDLE;
              fault <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stage_responder.sv
module tb_stage_responder;

  logic       clk;
  logic       rst;
  logic       en1, en2, en3, en4;
  logic       sw1, sw2, sw3;
  logic       seq_done;
  logic       busy;
  logic [2:0] stage;
  logic       fault;
  logic [1:0] dbg_state;

  int checks;
  int errors;

  stage_responder #(
    .T1(3), .T2(8), .T3(12), .T4(4), .CW(8), .WDT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .en1(en1), .en2(en2), .en3(en3), .en4(en4),
    .sw1(sw1), .sw2(sw2), .sw3(sw3),
    .seq_done(seq_done), .busy(busy), .stage(stage), .fault(fault),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [3:0] v);
    {en4, en3, en2, en1} = v;
  endtask

  task automatic idle_out();
    set_en(4'b0000);
    tick();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    set_en(4'b0000);
    #2;
    checks++;
    if ({sw1, sw2, sw3, seq_done, busy, stage, fault, dbg_state} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {sw1, sw2, sw3, seq_done, busy, stage, fault, dbg_state});
    end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (dbg_state !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: state=%0d busy=%b expected 0 0", dbg_state, busy);
    end
  endtask

  task automatic test_stage1();
    set_en(4'b0001);
    tick(); // edge E
    checks++;
    if (busy !== 1'b1 || stage !== 3'd1 || sw1 !== 1'b0) begin
      errors++;
      $display("FAIL s1_entry: busy=%b stage=%0d sw1=%b expected 1 1 0", busy, stage, sw1);
    end
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++;
      if (sw1 !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL s1_running E+%0d: sw1=%b busy=%b expected 0 1", i, sw1, busy);
      end
    end
    tick(); // E+3
    checks++;
    if (sw1 !== 1'b1 || busy !== 1'b0 || stage !== 3'd1 || dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL s1_done: sw1=%b busy=%b stage=%0d state=%0d expected 1 0 1 2",
               sw1, busy, stage, dbg_state);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (sw1 !== 1'b1 || sw2 !== 1'b0 || sw3 !== 1'b0) begin
      errors++;
      $display("FAIL s1_hold: sw=%b%b%b expected 100", sw1, sw2, sw3);
    end
    set_en(4'b0000);
    tick();
    checks++;
    if (sw1 !== 1'b0 || stage !== 3'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL s1_release: sw1=%b stage=%0d state=%0d expected 0 0 0", sw1, stage, dbg_state);
    end
    idle_out();
  endtask

  task automatic test_advance();
    set_en(4'b0001);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (sw1 !== 1'b1) begin
      errors++;
      $display("FAIL adv_pre_done: sw1=%b expected 1", sw1);
    end
    set_en(4'b0010);
    tick();
    checks++;
    if (sw1 !== 1'b0 || stage !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL adv_switch: sw1=%b stage=%0d busy=%b expected 0 2 1", sw1, stage, busy);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (sw2 !== 1'b0) begin
        errors++;
        $display("FAIL adv_sw2_early E+%0d: sw2=%b expected 0", i, sw2);
      end
    end
    tick(); // E+8
    checks++;
    if (sw2 !== 1'b1 || sw1 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL adv_sw2_rise: sw2=%b sw1=%b busy=%b expected 1 0 0", sw2, sw1, busy);
    end
    idle_out();
  endtask

  task automatic test_abort();
    set_en(4'b0100);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (sw3 !== 1'b0 || stage !== 3'd3 || busy !== 1'b1) begin
        errors++;
        $display("FAIL abort_run %0d: sw3=%b stage=%0d busy=%b expected 0 3 1", i, sw3, stage, busy);
      end
    end
    set_en(4'b0000);
    tick();
    checks++;
    if (dbg_state !== 2'd0 || busy !== 1'b0 || stage !== 3'd0) begin
      errors++;
      $display("FAIL abort_idle: state=%0d busy=%b stage=%0d expected 0 0 0", dbg_state, busy, stage);
    end
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (sw3 !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_sw3: sw3=%b expected 0", sw3);
    end
  endtask

  task automatic test_stage4();
    set_en(4'b1000);
    tick(); // edge E
    set_en(4'b0000);
    checks++;
    if (busy !== 1'b1 || stage !== 3'd4 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL s4_entry: busy=%b stage=%0d seq_done=%b expected 1 4 0", busy, stage, seq_done);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || stage !== 3'd4 || seq_done !== 1'b0) begin
        errors++;
        $display("FAIL s4_run E+%0d: busy=%b stage=%0d seq_done=%b expected 1 4 0",
                 i, busy, stage, seq_done);
      end
    end
    tick(); // E+4
    checks++;
    if (seq_done !== 1'b1 || busy !== 1'b0 || stage !== 3'd0) begin
      errors++;
      $display("FAIL s4_done: seq_done=%b busy=%b stage=%0d expected 1 0 0", seq_done, busy, stage);
    end
    tick();
    checks++;
    if (seq_done !== 1'b0) begin
      errors++;
      $display("FAIL s4_pulse_width: seq_done=%b expected 0", seq_done);
    end
  endtask

  task automatic test_fault();
    set_en(4'b0011);
    tick();
    checks++;
    if (fault !== 1'b1 || {sw1, sw2, sw3} !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fault_enter: fault=%b sw=%b%b%b busy=%b expected 1 000 0",
               fault, sw1, sw2, sw3, busy);
    end
    set_en(4'b0001);
    tick();
    checks++;
    if (fault !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky: fault=%b busy=%b expected 1 0", fault, busy);
    end
    set_en(4'b0000);
    tick();
    checks++;
    if (fault !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL fault_exit: fault=%b state=%0d expected 0 0", fault, dbg_state);
    end
    // fault out of DONE must drop the held sw
    set_en(4'b0001);
    for (int i = 0; i < 4; i++) tick();
    set_en(4'b0101);
    tick();
    checks++;
    if (fault !== 1'b1 || sw1 !== 1'b0) begin
      errors++;
      $display("FAIL fault_from_done: fault=%b sw1=%b expected 1 0", fault, sw1);
    end
    idle_out();
  endtask

  task automatic test_done_hold();
    set_en(4'b0001);
    for (int i = 0; i < 4; i++) tick(); // DONE entered at the 4th edge
`ifdef STAGE_WDT_EN
    for (int i = 1; i < 64; i++) begin
      tick();
      checks++;
      if (fault !== 1'b0 || sw1 !== 1'b1) begin
        errors++;
        $display("FAIL wdt_early D+%0d: fault=%b sw1=%b expected 0 1", i, fault, sw1);
      end
    end
    tick(); // D+64
    checks++;
    if (fault !== 1'b1 || sw1 !== 1'b0) begin
      errors++;
      $display("FAIL wdt_trip: fault=%b sw1=%b expected 1 0", fault, sw1);
    end
`else
    for (int i = 0; i < 70; i++) tick();
    checks++;
    if (fault !== 1'b0 || sw1 !== 1'b1) begin
      errors++;
      $display("FAIL done_hold: fault=%b sw1=%b expected 0 1", fault, sw1);
    end
`endif
    idle_out();
  endtask

  task automatic test_async_reset();
    set_en(4'b0100);
    tick();
    tick();
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({sw1, sw2, sw3, seq_done, busy, stage, fault, dbg_state} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got %b expected all zero",
               {sw1, sw2, sw3, seq_done, busy, stage, fault, dbg_state});
    end
    set_en(4'b0000);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (dbg_state !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_release: state=%0d busy=%b expected 0 0", dbg_state, busy);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stage1();
    test_advance();
    test_abort();
    test_stage4();
    test_fault();
    test_done_hold();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
